// File: rtl/gray_step_sequencer.sv
// Command-driven Gray-code position sequencer: steps a binary/Gray position
// counter up or down a set number of times at a programmable rate.
module gray_step_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic              abort,
    output logic [WIDTH-1:0]  bin_out,
    output logic [WIDTH-1:0]  gray_out,
    output logic              step_strobe,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic                strobe_q, strobe_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                dir_q, dir_d;

    // Ready depends on rst combinationally so no command is taken during reset.
    assign cmd_ready   = (state_q == IDLE) && rst;
    assign busy        = (state_q == RUN) || (state_q == FINISH);
    assign done        = (state_q == FINISH);
    assign aborted     = (state_q == ABORT);
    assign bin_out     = bin_q;
    assign gray_out    = bin_q ^ (bin_q >> 1);
    assign step_strobe = strobe_q;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        strobe_d    = 1'b0;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        div_d       = div_q;
        dir_d       = dir_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_d       = cmd_dir;
                    div_d       = cmd_div;
                    remaining_d = cmd_steps;
                    presc_d     = cmd_div;
                    state_d     = (cmd_steps == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                // Abort wins over a step that falls due on the same edge.
                if (abort) begin
                    state_d = ABORT;
                end else if (presc_q != '0) begin
                    presc_d = presc_q - DIV_W'(1);
                end else begin
                    bin_d       = dir_q ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
                    strobe_d    = 1'b1;
                    remaining_d = remaining_q - STEP_W'(1);
                    presc_d     = div_q;
                    if (remaining_q == STEP_W'(1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: state_d = IDLE;
            ABORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            strobe_q    <= 1'b0;
            remaining_q <= '0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            strobe_q    <= strobe_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
        end
    end

    // Latched command fields are only meaningful while a command runs.
    always_ff @(posedge clk) begin
        div_q <= div_d;
        dir_q <= dir_d;
    end

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Directed bench for gray_step_sequencer: table of commands plus hand-written
// abort, busy-protection and reset sequences.
module tb_gray_step_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic [7:0] cmd_div = '0;
    logic       abort = 1'b0;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       step_strobe;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks = 0;
    int errors = 0;

    gray_step_sequencer #(.WIDTH(4), .STEP_W(8), .DIV_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dir     (cmd_dir),
        .cmd_steps   (cmd_steps),
        .cmd_div     (cmd_div),
        .abort       (abort),
        .bin_out     (bin_out),
        .gray_out    (gray_out),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dir;
        logic [7:0] steps;
        logic [7:0] div;
        int         exp_bin;
        int         exp_strobes;
        int         exp_lat;
        int         exp_first;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    // Issues one command and follows it to done, checking every step.
    task automatic run_cmd(input logic dir, input logic [7:0] steps, input logic [7:0] div,
                           input int exp_bin, input int exp_strobes, input int exp_lat,
                           input int exp_first);
        int n, strobes, first, prev_bin, prev_gray;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps;
        cmd_div   = div;
        check("ready_before_accept", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        // Scramble command inputs: they must not matter after acceptance.
        cmd_dir   = ~dir;
        cmd_steps = 8'd7;
        cmd_div   = 8'd5;
        n = 0; strobes = 0; first = 0;
        prev_bin  = int'(bin_out);
        prev_gray = int'(gray_out);
        while (!done && n < 2000) begin
            tick();
            n++;
            if (step_strobe) begin
                strobes++;
                if (first == 0) first = n;
                check("step_value", int'(bin_out), dir ? ((prev_bin + 1) & 15) : ((prev_bin + 15) & 15));
                check("gray_one_bit", $countones(gray_out ^ prev_gray), 1);
            end else begin
                check("hold_between_steps", int'(bin_out), prev_bin);
            end
            prev_bin  = int'(bin_out);
            prev_gray = int'(gray_out);
        end
        check("done_latency", n, exp_lat);
        check("strobe_count", strobes, exp_strobes);
        check("first_step_edge", first, exp_first);
        check("final_bin", int'(bin_out), exp_bin);
        check("final_gray", int'(gray_out), gray_of(exp_bin));
        check("busy_at_done", int'(busy), 1);
        tick();
        check("ready_after_done", int'(cmd_ready), 1);
        check("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'd16, 8'd0, 0,  16, 16, 1};
        vecs[1] = '{1'b0, 8'd3,  8'd2, 13, 3,  9,  3};
        vecs[2] = '{1'b1, 8'd0,  8'd4, 13, 0,  0,  0};
        vecs[3] = '{1'b1, 8'd5,  8'd1, 2,  5,  10, 2};
        vecs[4] = '{1'b0, 8'd2,  8'd3, 0,  2,  8,  4};

        // Reset held for two edges.
        rst = 1'b0;
        tick();
        tick();
        check("rst_bin", int'(bin_out), 0);
        check("rst_gray", int'(gray_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_strobe", int'(step_strobe), 0);
        check("rst_ready_low", int'(cmd_ready), 0);
        rst = 1'b1;
        #1;
        check("ready_after_release", int'(cmd_ready), 1);
        tick();

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].dir, vecs[i].steps, vecs[i].div, vecs[i].exp_bin,
                    vecs[i].exp_strobes, vecs[i].exp_lat, vecs[i].exp_first);
        end

        // Abort on the edge where step 3 is due (k+6 for div=1), from position 0.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd10; cmd_div = 8'd1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_done", int'(done), 0);
        end
        check("abort_pre_pos", int'(bin_out), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", int'(aborted), 1);
        check("abort_pos", int'(bin_out), 2);
        check("abort_no_step", int'(step_strobe), 0);
        check("abort_done_low", int'(done), 0);
        check("abort_busy_low", int'(busy), 0);
        tick();
        check("abort_single_pulse", int'(aborted), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_done_never", int'(done), 0);
        run_cmd(1'b1, 8'd1, 8'd0, 3, 1, 1, 1);

        // Busy protection: a second command during RUN must be ignored.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd4; cmd_div = 8'd0;
        tick();
        cmd_dir = 1'b0; cmd_steps = 8'd9;
        check("busy_ready_low", int'(cmd_ready), 0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) tick();
        check("busy_done", int'(done), 1);
        check("busy_final_pos", int'(bin_out), 7);
        tick();
        tick();
        check("busy_not_queued", int'(busy), 0);
        check("busy_pos_held", int'(bin_out), 7);

        // Mid-command reset clears position within one edge.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd8; cmd_div = 8'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("midrst_pre_pos", int'(bin_out), 9);
        rst = 1'b0;
        tick();
        check("midrst_bin", int'(bin_out), 0);
        check("midrst_gray", int'(gray_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready_low", int'(cmd_ready), 0);
        rst = 1'b1;
        tick();
        check("midrst_stays_idle", int'(busy), 0);
        check("midrst_pos_held", int'(bin_out), 0);
        check("midrst_ready", int'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
